mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter that shares the CPU's single-port unified memory between instruction fetch and data load/store. It sits inside `cpu_top` between the fetch and memory stages and the memory model. It serialises their transactions through a request/ready handshake with data-priority and a fetch-starvation guard. It also runs a watchdog that aborts any memory transaction that never completes.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte strobes = DATA_W/8)
- `MAX_D_STREAK`, 4, consecutive data grants allowed while fetch is pending
- `TIMEOUT`, 255, cycles in BUSY without `mem_ready` before abort
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — synchronous reset, active-high
- `i_req` in 1 — fetch request
- `i_addr` in ADDR_W — fetch address
- `i_ready` out 1 — fetch response pulse
- `i_rdata` out DATA_W — fetch read data
- `d_req` in 1 — data request
- `d_we` in 1 — write enable
- `d_addr` in ADDR_W — data address
- `d_wdata` in DATA_W — write data
- `d_wstrb` in DATA_W/8 — write byte strobes
- `d_ready` out 1 — data response pulse
- `d_rdata` out DATA_W — load data
- `mem_req` out 1 — memory request
- `mem_we` out 1 — memory write enable
- `mem_addr` out ADDR_W — memory address
- `mem_wdata` out DATA_W — memory write data
- `mem_wstrb` out DATA_W/8 — memory byte strobes
- `mem_ready` in 1 — memory completion
- `mem_rdata` in DATA_W — memory read data
- `bus_err` out 1 — sticky timeout flag, cleared only by `rst`

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register: NONE, IFETCH, DATA.
- IDLE, arbitration:
  - Only `d_req` set: grant DATA.
  - Only `i_req` set: grant IFETCH.
  - Both set: grant DATA unless `streak == MAX_D_STREAK`; in that case grant IFETCH.
  - On a grant: latch the winner's request into the `mem_*` registers, then go to BUSY.
- Streak counter:
  - Increments on a DATA grant while `i_req` is high.
  - Clears on any IFETCH grant.
  - Clears on a DATA grant while `i_req` is low.
  - Saturates at `MAX_D_STREAK`.
- BUSY:
  - `mem_req` is held at 1 with stable `mem_*` fields.
  - On `mem_ready`: capture `mem_rdata` into the owner's rdata register, go to RESP.
  - Timeout counter increments each BUSY cycle without `mem_ready`.
  - When the counter reaches `TIMEOUT`: set `bus_err`, load rdata = 0, go to RESP. Requesters are never hung.
- RESP:
  - The owner's `x_ready` = 1 for exactly one cycle. `mem_req` = 0.
  - Return to IDLE. No grant is issued in RESP.
- Requester contract:
  - Hold `x_req` and its fields stable from assertion until `x_ready`.
  - `x_req` still high in the cycle after `x_ready` is a new request.
- For fetch transactions, `mem_we` = 0 and `mem_wstrb` = 0.
- `i_rdata` and `d_rdata` hold their last captured value until the next capture for that port.
- Loads with `d_we` = 0 pass `d_wstrb` through unmodified; memory ignores it.

## Timing
- Reset values:
  - State IDLE, owner NONE, streak 0, timeout counter 0.
  - `mem_req`, `mem_we`, `i_ready`, `d_ready`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `mem_wstrb`, `i_rdata`, `d_rdata` = 0.
- All outputs are registered; no combinational input-to-output path.
- Latency with a zero-wait memory (`mem_ready` high in the first BUSY cycle):
  - Request seen at edge N.
  - `mem_req` high in cycle N+1.
  - `x_ready` high in cycle N+2.
  - Back-to-back occupancy is 3 cycles per transaction.
- Each memory wait cycle adds 1 to latency.
- Reset mid-transaction (BUSY or RESP) drops the transaction. No `x_ready` is issued and `bus_err` clears.
- `mem_ready` outside BUSY is ignored.
- A request arriving during BUSY or RESP waits; it is evaluated in the next IDLE cycle.

## Structure
- Shared package `cpu_bus_pkg`:
  - `arb_state_e` (IDLE/BUSY/RESP)
  - `arb_owner_e` (NONE/IFETCH/DATA)
  - Default width constants
- Optional sub-module `bus_watchdog`:
  - Timeout counter with enable, clear and a `expired` output.
  - Instantiated once.
- Everything else stays in `mem_bus_arbiter`.

## Test plan
- **Single fetch:** `i_req`=1, `i_addr`=0x100; memory returns 0x00000013 with 0 waits. Expect `mem_req` at N+1 with `mem_addr`=0x100 and `mem_we`=0; `i_ready`=1 at N+2 with `i_rdata`=0x00000013.
- **Simultaneous requests:** `i_req` and `d_req` both set, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF. Expect DATA served first with `mem_we`=1 and the write fields passed to `mem_*`, then fetch served; `d_ready` precedes `i_ready` by 3 cycles.
- **Starvation guard:** both requests held continuously with `MAX_D_STREAK`=4. Expect grant order D,D,D,D,I,D…; streak returns to 0 after the I grant.
- **Wait states:** memory inserts 5 wait cycles on a load from 0x40. Expect `mem_req` held 6 cycles with stable fields and `d_ready` at N+7.
- **Timeout:** `mem_ready` never asserts with `TIMEOUT`=255. Expect `bus_err`=1 after 255 BUSY cycles and `d_ready` pulses with `d_rdata`=0. Expect `bus_err` to stay 1 through later good transactions until `rst`.
- **Reset mid-BUSY:** assert `rst` for 1 cycle during BUSY. Expect all outputs at reset values the next cycle, no `x_ready` pulse, and the FSM to re-arbitrate normally afterward.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and default widths for the CPU memory-bus arbiter and its watchdog.
package cpu_bus_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_MAX_D_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT      = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE,
    IFETCH,
    DATA
  } arb_owner_e;

endpackage

// File: rtl/bus_watchdog.sv
// Counts stalled cycles of a memory transaction and flags the cycle in which
// the LIMIT-th consecutive stall occurs.
module bus_watchdog #(
  parameter int unsigned LIMIT = cpu_bus_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Fires during the stall that would take the count to LIMIT.
  assign expired = en && (count_q == CNT_W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access: data has
// priority, a streak limit guarantees fetch progress, a watchdog aborts hung accesses.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SW     = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              wd_en, wd_clr, wd_expired;
  logic [DATA_W-1:0] resp_data;

  assign wd_en     = (state_q == BUSY) && !mem_ready;
  assign wd_clr    = (state_q != BUSY);
  assign resp_data = mem_ready ? mem_rdata : '0;

  bus_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (wd_en),
    .clr     (wd_clr),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && streak_q == STREAK_MAX)) begin
          state_d     = BUSY;
          owner_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          // The guard above keeps this increment from passing STREAK_MAX.
          streak_d    = i_req ? streak_q + SW'(1) : '0;
        end else if (i_req) begin
          state_d     = BUSY;
          owner_d     = IFETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          streak_d    = '0;
        end
      end
      BUSY: begin
        if (mem_ready || wd_expired) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          bus_err_d = bus_err_q | !mem_ready;
          if (owner_q == DATA) begin
            d_ready_d = 1'b1;
            d_rdata_d = resp_data;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = resp_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign i_ready   = i_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 255;
  localparam int MAX_D   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        i_ready, d_ready, mem_req, mem_we, bus_err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int tests = 0;
  int fails = 0;
  int mem_waits = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: asserts mem_ready after mem_waits stalled cycles.
  always @(negedge clk) begin
    mem_rdata = rd_val(mem_addr);
    if (mem_req === 1'b1) begin
      mem_ready = (busy_cnt == mem_waits);
      busy_cnt++;
    end else begin
      mem_ready = 1'b0;
      busy_cnt  = 0;
    end
  end

  // Reference model: one transaction at a time, response cycle after completion.
  bit          model_on = 0;
  bit          m_active, m_resp;
  int          m_age, m_src, m_streak;
  logic        e_mem_req, e_mem_we, e_i_ready, e_d_ready, e_bus_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_i_rdata, e_d_rdata;
  logic [3:0]  e_mem_wstrb;

  always @(posedge clk) begin
    logic [31:0] v;
    if (rst) begin
      model_on = 1; m_active = 0; m_resp = 0; m_age = 0; m_src = 0; m_streak = 0;
      e_mem_req = 0; e_mem_we = 0; e_i_ready = 0; e_d_ready = 0; e_bus_err = 0;
      e_mem_addr = 0; e_mem_wdata = 0; e_i_rdata = 0; e_d_rdata = 0; e_mem_wstrb = 0;
    end else if (model_on) begin
      e_i_ready = 0;
      e_d_ready = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (m_active) begin
        m_age++;
        if (mem_ready || m_age >= TIMEOUT) begin
          v = mem_ready ? rd_val(e_mem_addr) : 32'h0;
          if (!mem_ready) e_bus_err = 1;
          if (m_src == 2) begin e_d_ready = 1; e_d_rdata = v; end
          else begin e_i_ready = 1; e_i_rdata = v; end
          e_mem_req = 0; m_active = 0; m_resp = 1;
        end
      end else if (d_req || i_req) begin
        if (d_req && !(i_req && m_streak >= MAX_D)) begin
          m_src = 2; e_mem_we = d_we; e_mem_addr = d_addr;
          e_mem_wdata = d_wdata; e_mem_wstrb = d_wstrb;
          m_streak = i_req ? ((m_streak + 1 > MAX_D) ? MAX_D : m_streak + 1) : 0;
        end else begin
          m_src = 1; e_mem_we = 0; e_mem_addr = i_addr;
          e_mem_wdata = 0; e_mem_wstrb = 0; m_streak = 0;
        end
        e_mem_req = 1; m_active = 1; m_age = 0;
      end
    end
  end

  // Per-cycle comparison against the model, one log line per completed transaction.
  always @(negedge clk) begin
    if (model_on) begin
      chk("mem_req", {31'b0, mem_req}, {31'b0, e_mem_req});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_mem_we});
      chk("mem_addr", mem_addr, e_mem_addr);
      chk("mem_wdata", mem_wdata, e_mem_wdata);
      chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e_mem_wstrb});
      chk("i_ready", {31'b0, i_ready}, {31'b0, e_i_ready});
      chk("d_ready", {31'b0, d_ready}, {31'b0, e_d_ready});
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("bus_err", {31'b0, bus_err}, {31'b0, e_bus_err});
      if (d_ready === 1'b1) $display("[TB] t=%0t D txn rdata=%h bus_err=%b", $time, d_rdata, bus_err);
      if (i_ready === 1'b1) $display("[TB] t=%0t I txn rdata=%h bus_err=%b", $time, i_rdata, bus_err);
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    string got;
    int    cnt;
    rst = 1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    rst = 0;
    @(negedge clk);

    // Single fetch, zero-wait memory.
    mem_waits = 0;
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    chk("fetch_mem_req", {31'b0, mem_req}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("fetch_i_ready", {31'b0, i_ready}, 32'd1);
    chk("fetch_i_rdata", i_rdata, 32'h0000_0013);
    i_req = 0;
    repeat (2) @(negedge clk);

    // Simultaneous requests: data write first, fetch three cycles later.
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    @(negedge clk);
    chk("sim_mem_we", {31'b0, mem_we}, 32'd1);
    chk("sim_mem_addr", mem_addr, 32'h2000);
    chk("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sim_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
    @(negedge clk);
    chk("sim_d_ready", {31'b0, d_ready}, 32'd1);
    d_req = 0; d_we = 0;
    repeat (2) @(negedge clk);
    chk("sim_fetch_addr", mem_addr, 32'h104);
    chk("sim_fetch_wstrb", {28'b0, mem_wstrb}, 32'h0);
    @(negedge clk);
    chk("sim_i_ready_plus3", {31'b0, i_ready}, 32'd1);
    i_req = 0;
    repeat (2) @(negedge clk);

    // Starvation guard: both requests held, load passes its strobes through.
    got = "";
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 0; d_addr = 32'h80; d_wstrb = 4'h3;
    @(negedge clk);
    chk("starve_load_wstrb", {28'b0, mem_wstrb}, 32'h3);
    for (int k = 0; k < 60 && got.len() < 10; k++) begin
      @(negedge clk);
      if (d_ready === 1'b1) got = {got, "D"};
      if (i_ready === 1'b1) got = {got, "I"};
    end
    i_req = 0; d_req = 0;
    tests++;
    if (got != "DDDDIDDDDI") begin
      fails++;
      $display("FAIL starve_order: got %s expected DDDDIDDDDI", got);
    end
    repeat (3) @(negedge clk);

    // Five memory wait states on a load.
    mem_waits = 5;
    d_req = 1; d_we = 0; d_addr = 32'h40; d_wstrb = 4'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("wait_mem_req", {31'b0, mem_req}, 32'd1);
      chk("wait_mem_addr", mem_addr, 32'h40);
    end
    @(negedge clk);
    chk("wait_d_ready", {31'b0, d_ready}, 32'd1);
    chk("wait_d_rdata", d_rdata, 32'h0040_FFBF);
    d_req = 0;
    repeat (2) @(negedge clk);

    // Timeout: memory never answers.
    mem_waits = 1000000;
    cnt = 0;
    d_req = 1; d_addr = 32'h44;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (d_ready === 1'b1) break;
      if (mem_req === 1'b1) cnt++;
    end
    chk("timeout_busy_cycles", cnt, 32'd255);
    chk("timeout_d_ready", {31'b0, d_ready}, 32'd1);
    chk("timeout_d_rdata", d_rdata, 32'd0);
    chk("timeout_bus_err", {31'b0, bus_err}, 32'd1);
    d_req = 0;
    mem_waits = 0;
    repeat (2) @(negedge clk);
    i_req = 1; i_addr = 32'h100;
    repeat (2) @(negedge clk);
    chk("sticky_i_ready", {31'b0, i_ready}, 32'd1);
    chk("sticky_i_rdata", i_rdata, 32'h0000_0013);
    chk("sticky_bus_err", {31'b0, bus_err}, 32'd1);
    i_req = 0;
    repeat (2) @(negedge clk);

    // Reset while BUSY drops the transaction.
    mem_waits = 3;
    d_req = 1; d_addr = 32'h48;
    repeat (2) @(negedge clk);
    rst = 1; d_req = 0;
    @(negedge clk);
    chk("rstbusy_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rstbusy_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rstbusy_d_rdata", d_rdata, 32'd0);
    chk("rstbusy_mem_addr", mem_addr, 32'd0);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstbusy_no_d_ready", {31'b0, d_ready}, 32'd0);
    end
    mem_waits = 0;
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    chk("rearb_mem_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    chk("rearb_i_ready", {31'b0, i_ready}, 32'd1);
    chk("rearb_i_rdata", i_rdata, 32'h0000_0013);
    i_req = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
